// File: rtl/baby_kyber_encrypt.sv
// baby_kyber_encrypt: Baby-Kyber encryption, u = A^T*r + e1, v = t^T*r + e2 + 9*m, over Z17[x]/(x^4+1).
// ENC_MAC4_EN selects four parallel multipliers (24 MAC cycles) instead of one (96 MAC cycles).
`timescale 1ns/1ps
module baby_kyber_encrypt (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic signed [3:0][3:0][31:0] pk_a,
   input  logic signed [1:0][3:0][31:0] pk_t,
   input  logic [3:0]                 msg,
   input  logic signed [1:0][3:0][31:0] r,
   input  logic signed [1:0][3:0][31:0] e1,
   input  logic signed [3:0][31:0]    e2,
   output logic                       busy,
   output logic                       done,
   output logic signed [1:0][3:0][31:0] ct_u,
   output logic signed [3:0][31:0]    ct_v
);
   localparam int Q = 17;
   localparam int HALF_Q = 9;
`ifdef ENC_MAC4_EN
   localparam int LANES = 4;
   localparam int CW = 5;
`else
   localparam int LANES = 1;
   localparam int CW = 7;
`endif
   localparam logic [CW-1:0] LAST = CW'(96 / LANES - 1);
   typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0] p_idx, k_idx, i_base, ii;
   logic j_idx, grp_first, grp_last;
   logic [4:0] op_a, op_r;
   int acc, acc_nxt, step, prod;
   logic [3:0][3:0][4:0] a_q;
   logic [1:0][3:0][4:0] t_q, r_q, e1_q;
   logic [3:0][4:0] e2_q;
   logic [3:0] m_q;
   logic [2:0][3:0][4:0] coef;
`ifdef ENC_MAC4_EN
   assign {p_idx, k_idx, j_idx} = cnt;
   assign i_base = 2'd0;
   assign grp_first = !j_idx;
   assign grp_last = j_idx;
`else
   assign {p_idx, k_idx, j_idx, i_base} = cnt;
   assign grp_first = cnt[2:0] == 3'd0;
   assign grp_last = cnt[2:0] == 3'd7;
`endif
   function automatic logic [4:0] mod_q(input int x);
      int m;
      m = ((x % Q) + Q) % Q;
      return 5'(m);
   endfunction
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // next-state logic
   always_comb
      state_nxt = state == IDLE ? (start ? MAC : IDLE) :
                  state == MAC  ? (cnt == LAST ? FINAL : MAC) : IDLE;
   // output decode
   always_comb
      busy = state != IDLE;
   // negacyclic partial products for the current (p,k,j) and lane(s) of i
   always_comb begin
      step = 0;
      ii = '0;
      op_a = '0;
      op_r = '0;
      prod = 0;
      for (int l = 0; l < LANES; l++) begin
         ii = i_base + 2'(l);
         op_a = p_idx == 2'd2 ? t_q[j_idx][ii] : a_q[{j_idx, p_idx[0]}][ii];
         op_r = r_q[j_idx][k_idx - ii];
         prod = int'(op_a) * int'(op_r);
         step = ii > k_idx ? step - prod : step + prod;
      end
      acc_nxt = grp_first ? step : acc + step;
   end
   // operand capture, MAC accumulation and final ciphertext assembly
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         acc <= 0;
         done <= 1'b0;
         a_q <= '0;
         t_q <= '0;
         r_q <= '0;
         e1_q <= '0;
         e2_q <= '0;
         m_q <= '0;
         coef <= '0;
         ct_u <= '0;
         ct_v <= '0;
      end else begin
         done <= state == FINAL;
         if (state == IDLE && start) begin
            cnt <= '0;
            acc <= 0;
            m_q <= msg;
            for (int i = 0; i < 4; i++) begin
               e2_q[i] <= mod_q(e2[i]);
               for (int j = 0; j < 4; j++) a_q[i][j] <= mod_q(pk_a[i][j]);
            end
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 4; j++) begin
                  t_q[i][j] <= mod_q(pk_t[i][j]);
                  r_q[i][j] <= mod_q(r[i][j]);
                  e1_q[i][j] <= mod_q(e1[i][j]);
               end
         end
         if (state == MAC) begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            acc <= acc_nxt;
            if (grp_last) coef[p_idx][k_idx] <= mod_q(acc_nxt);
         end
         if (state == FINAL)
            for (int k = 0; k < 4; k++) begin
               ct_v[k] <= {27'd0, mod_q(int'(coef[2][k]) + int'(e2_q[k]) + (m_q[k] ? HALF_Q : 0))};
               for (int p = 0; p < 2; p++)
                  ct_u[p][k] <= {27'd0, mod_q(int'(coef[p][k]) + int'(e1_q[p][k]))};
            end
      end
endmodule

// File: tb/tb_baby_kyber_encrypt.sv
// tb_baby_kyber_encrypt: directed self-checking bench for baby_kyber_encrypt.
`timescale 1ns/1ps
module tb_baby_kyber_encrypt;
`ifdef ENC_MAC4_EN
   localparam int LAT = 25;
   localparam int PER = 26;
   localparam int P2 = 20;
`else
   localparam int LAT = 97;
   localparam int PER = 98;
   localparam int P2 = 50;
`endif
   logic clk = 1'b0;
   logic rst_n, start, busy, done;
   logic signed [3:0][3:0][31:0] pk_a;
   logic signed [1:0][3:0][31:0] pk_t, r, e1, ct_u;
   logic signed [3:0][31:0] e2, ct_v;
   logic [3:0] msg;
   int checks = 0;
   int failures = 0;
   int lat, dn, dc, d1, d2;
   baby_kyber_encrypt dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pk_a(pk_a), .pk_t(pk_t), .msg(msg),
      .r(r), .e1(e1), .e2(e2), .busy(busy), .done(done), .ct_u(ct_u), .ct_v(ct_v)
   );
   always #5 clk = ~clk;
   initial begin
      #3000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
   function automatic logic [127:0] poly(input int c0, input int c1, input int c2, input int c3);
      return {c3, c2, c1, c0};
   endfunction
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic clear_in();
      pk_a = '0; pk_t = '0; r = '0; e1 = '0; e2 = '0; msg = '0;
   endtask
   task automatic run_op(input string tag);
      lat = -1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 1'b0);
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b0; clear_in();
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ct_u", ct_u, '0);
      chk("rst_ct_v", ct_v, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      // message only
      msg = 4'b1011;
      run_op("msg");
      chk("msg_ct_u", ct_u, '0);
      chk("msg_ct_v", ct_v, poly(9, 9, 0, 9));
      // negacyclic wrap: x^3 * x = -1
      clear_in();
      pk_a[0][3] = 1; r[0][1] = 1;
      run_op("wrap");
      chk("wrap_ct_u", ct_u, {poly(0, 0, 0, 0), poly(16, 0, 0, 0)});
      chk("wrap_ct_v", ct_v, '0);
      // negative input reduction
      clear_in();
      for (int i = 0; i < 4; i++) begin
         pk_t[0][i] = -1; e2[i] = -1;
         for (int j = 0; j < 4; j++) pk_a[i][j] = -16;
      end
      r[0][0] = 1; e1[0][0] = 1; e1[1][0] = 1;
      run_op("neg");
      chk("neg_ct_u", ct_u, {poly(2, 1, 1, 1), poly(2, 1, 1, 1)});
      chk("neg_ct_v", ct_v, poly(15, 15, 15, 15));
      // mixed: (1+2x)(3+x^3) = {1,6,0,1}; x^2*2x^2 = -2; msg bit0 adds 9
      clear_in();
      pk_a[0][0] = 1; pk_a[0][1] = 2; r[0][0] = 3; r[0][3] = 1; e1[0][0] = -1;
      pk_t[1][2] = 1; r[1][2] = 2; msg = 4'b0001;
      run_op("mix");
      chk("mix_ct_u", ct_u, {poly(0, 0, 0, 0), poly(0, 6, 0, 1)});
      chk("mix_ct_v", ct_v, poly(7, 0, 0, 0));
      // start pulses while busy are ignored
      clear_in();
      msg = 4'b1011;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      dn = 0; dc = -1;
      for (int c = 1; c <= 150; c++) begin
         start = (c == 10 || c == P2);
         if (c == 10) begin msg = 4'b0110; e2[0] = 5; end
         @(posedge clk); #1 start = 1'b0;
         if (done) begin dn++; dc = c; end
      end
      chk("hs_done_count", dn, 1);
      chk("hs_done_cycle", dc, LAT);
      chk("hs_ct_v", ct_v, poly(9, 9, 0, 9));
      // start held high
      clear_in();
      msg = 4'b1011;
      start = 1'b1;
      d1 = -1; d2 = -1;
      for (int c = 1; c <= 250; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
      end
      start = 1'b0;
      chk("held_first", d1, 1 + LAT);
      chk("held_period", d2 - d1, PER);
      for (int c = 0; c < 300 && (busy || done); c++) begin @(posedge clk); #1; end
      chk("held_idle", busy, 1'b0);
      // rerun mixed vector so outputs are nonzero before the abort
      clear_in();
      pk_a[0][0] = 1; pk_a[0][1] = 2; r[0][0] = 3; r[0][3] = 1; e1[0][0] = -1;
      pk_t[1][2] = 1; r[1][2] = 2; msg = 4'b0001;
      run_op("pre");
      chk("pre_ct_u", ct_u, {poly(0, 0, 0, 0), poly(0, 6, 0, 1)});
      // abort at cycle 40 with asynchronous reset
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_ct_u", ct_u, '0);
      chk("abort_ct_v", ct_v, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 120; c++) begin @(posedge clk); #1; if (done) dn++; end
      chk("abort_no_done", dn, 0);
      clear_in();
      msg = 4'b1011;
      run_op("after");
      chk("after_ct_u", ct_u, '0);
      chk("after_ct_v", ct_v, poly(9, 9, 0, 9));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/baby_kyber_encrypt.md
# baby_kyber_encrypt

Encryption stage downstream of key generation in the Baby-Kyber datapath (q = 17, n = 4, k = 2, ring Z17[x]/(x^4+1)). The block captures a public key (matrix A and vector t) plus message and noise, then computes ciphertext u = A^T·r + e1 and v = t^T·r + e2 + 9·m with a serial multiply-accumulate engine. It uses a start/busy/done handshake. Its public-key inputs connect directly to key generation's combined_output planes.

## Interface
- Q, 17, modulus; all outputs canonical 0..Q-1
- HALF_Q, 9, round(Q/2), the message encoding scale
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- pk_a  input  signed [31:0] [3:0][3:0]  A rows; row 2·i+j = A[i][j], 4 coefficients each
- pk_t  input  signed [31:0] [1:0][3:0]  t polynomials
- msg  input  [3:0]  message bit k maps to v coefficient k
- r  input  signed [31:0] [1:0][3:0]  ephemeral secret
- e1  input  signed [31:0] [1:0][3:0]  noise added to u
- e2  input  signed [31:0] [3:0]  noise added to v
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; ct_u and ct_v valid from this cycle
- ct_u  output  signed [31:0] [1:0][3:0]  ciphertext u
- ct_v  output  signed [31:0] [3:0]  ciphertext v

## Operation
- States:
  - IDLE: start=1 → MAC.
  - MAC: runs until the counter reaches its last value → FINAL.
  - FINAL: → IDLE unconditionally.
- Capture on the start edge:
  - All pk_a, pk_t, r, e1, e2 and msg are registered.
  - Each coefficient is reduced to 0..16 using ((x % 17) + 17) % 17, so negative inputs are legal.
- Three output polynomials: u0 = A_row0·r0 + A_row2·r1; u1 = A_row1·r0 + A_row3·r1; v = t0·r0 + t1·r1.
- Negacyclic product: c[k] = Σ a[i]·b[(k−i) mod 4], negated when i > k.
- MAC counter {p (0..2), k (0..3), j (0..1), i (0..3)}: 96 steps, one product per cycle.
  - A signed accumulator clears at the start of each (p,k) group.
  - At the end of a group, the accumulator is reduced mod 17 into an internal coefficient register.
- FINAL:
  - ct_u[p][k] = (coef + e1[p][k]) mod 17.
  - ct_v[k] = (coef + e2[k] + 9·msg[k]) mod 17.
  - Outputs register, done=1, busy=0.
- ct_u and ct_v hold until the next FINAL; they never show intermediate values.
- start while busy is ignored; there is no queuing.
- Accumulator bound is ±8·256, so 32-bit signed arithmetic is sufficient.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - State IDLE, counter 0, accumulator 0.
  - busy=0, done=0, all ct_u and ct_v coefficients = 0.
  - The aborted operation produces no done.
- Start sampled at edge N:
  - busy=1 from edge N.
  - MAC edges N+1..N+96.
  - FINAL edge N+97: done=1 and outputs updated; busy=0 from N+97.
- done drops at edge N+98.
- Earliest next start is sampled at edge N+98, so the back-to-back period is 98 cycles.
- Inputs need to be stable only at the start edge.

## Configuration
- ENC_MAC4_EN defined:
  - Four parallel multipliers process all i for one (p,k,j) per cycle.
  - 24 MAC cycles; done at edge N+25; back-to-back period 26.
- ENC_MAC4_EN undefined: single multiplier with the 96-cycle schedule above.
- Results are bit-identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-run → busy=0, done=0, all ct coefficients 0 immediately.
- Message only: all operands 0, msg=4'b1011 → ct_u all 0, ct_v={9,9,0,9}, done exactly 97 cycles after the start edge (25 with ENC_MAC4_EN).
- Negacyclic wrap: pk_a row0 = {0,0,0,1} (x^3), r0 = {0,1,0,0} (x), everything else 0 → ct_u[0]={16,0,0,0}, ct_u[1] and ct_v all 0.
- Negative reduction:
  - Stimulus: pk_t[0]={−1,−1,−1,−1}, r0={1,0,0,0}, e2={−1,−1,−1,−1}, pk_a={−16 everywhere}, r1=0, e1={1,0,0,0}.
  - Expected: ct_v={15,15,15,15}.
  - Expected: ct_u[0]={2,1,1,1}, from A_row0·r0 = {1,1,1,1}. Likewise ct_u[1]={2,1,1,1}.
- Handshake:
  - Start pulses at cycles 10 and 50 of a run → only one done; the result matches the first captured operands.
  - Start held high → done every 98 cycles.
- Abort: reset at cycle 40 of a run, then a new start with the message-only vector → no done from the aborted run, and a correct {9,9,0,9} result from the new start.
